// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS control sequencer.
// Holds the state encoding, opcode/funct values, datapath mux/ALU codes and
// the packed control-word payload driven onto the datapath.
package mips_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned ALU_W   = 3;

   // Sequencer states; BNEEX is only reachable when bne support is built in.
   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_HALT    = 4'd12,
      S_BNEEX   = 4'd13
   } state_e;

   // Opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   // R-type funct codes (IR[5:0])
   localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FN_W-1:0] FN_AND = 6'b100100;
   localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   // ALU B-input select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Control word presented to the datapath each cycle
   typedef struct packed {
      logic             pc_en;
      logic             iord;
      logic             mem_write;
      logic             ir_write;
      logic             reg_dst;
      logic             mem_to_reg;
      logic             reg_write;
      logic             alu_src_a;
      logic [1:0]       alu_src_b;
      logic [ALU_W-1:0] alu_ctrl;
      logic [1:0]       pc_src;
      logic             halted;
   } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: combinational R-type funct -> ALU operation decode.
// Ports: funct_i (IR[5:0]) in; alu_ctrl_o (ALU operation code) out.
// Unknown funct values fall back to add.
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [FN_W-1:0]  funct_i,
   output logic [ALU_W-1:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      unique case (funct_i)
         FN_SUB:  alu_ctrl_o = ALU_SUB;
         FN_AND:  alu_ctrl_o = ALU_AND;
         FN_OR:   alu_ctrl_o = ALU_OR;
         FN_SLT:  alu_ctrl_o = ALU_SLT;
         default: alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: Moore control sequencer for the multicycle MIPS datapath.
// Walks each instruction through FETCH/DECODE/execute/memory/writeback and
// drives the PC, IR, memory, register-file and ALU mux controls.
// Parameter: ILLEGAL_HALT (1 = unknown opcode halts, 0 = treated as NOP).
// Build option: define MIPS_MC_BNE_EN to add bne support (state BNEEX).
// Ports:
//   clk, rst (sync, active-high)             clock / reset
//   op, funct, zero                          IR fields and ALU zero flag
//   pc_en, iord, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_ctrl, pc_src   datapath controls
//   state, halted                            debug/status
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op,
   input  logic [FN_W-1:0]    funct,
   input  logic               zero,
   output logic               pc_en,
   output logic               iord,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALU_W-1:0]   alu_ctrl,
   output logic [1:0]         pc_src,
   output logic [STATE_W-1:0] state,
   output logic               halted
);

   state_e           state_q, state_d;
   state_e           illegal_tgt;
   logic [ALU_W-1:0] rtype_alu;
   ctrl_t            ctrl;

   mips_alu_dec u_alu_dec (
      .funct_i    (funct),
      .alu_ctrl_o (rtype_alu)
   );

   assign illegal_tgt = ILLEGAL_HALT ? S_HALT : S_FETCH;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next-state logic; IR is stable until the next FETCH, so MEMADR re-reads op
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            unique case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       state_d = S_BNEEX;
`endif
               default:      state_d = illegal_tgt;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = S_FETCH;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
`ifdef MIPS_MC_BNE_EN
         S_BNEEX:   state_d = S_FETCH;
`endif
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode; only the branch states look at zero
   always_comb begin
      ctrl = '0;
      unique case (state_q)
         S_FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_ctrl  = ALU_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.pc_en     = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM4;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_ctrl  = rtype_alu;
         end
         S_RTYPEWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_ctrl  = ALU_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.pc_en     = zero;
         end
`ifdef MIPS_MC_BNE_EN
         S_BNEEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_ctrl  = ALU_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.pc_en     = ~zero;
         end
`endif
         S_ADDIWB: ctrl.reg_write = 1'b1;
         S_JEX: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
         S_HALT:  ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

   // Enables are masked while reset is being applied so no write escapes
   assign pc_en      = ctrl.pc_en     & ~rst;
   assign mem_write  = ctrl.mem_write & ~rst;
   assign ir_write   = ctrl.ir_write  & ~rst;
   assign reg_write  = ctrl.reg_write & ~rst;
   assign iord       = ctrl.iord;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_ctrl   = ctrl.alu_ctrl;
   assign pc_src     = ctrl.pc_src;
   assign halted     = ctrl.halted;
   assign state      = STATE_W'(state_q);

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control sequencer for the MIPS datapath. It replaces single-cycle combinational decode with a Moore state machine that walks each instruction through fetch, decode, execute, memory and writeback. Each step drives the PC, instruction-register, memory, register-file and ALU-mux enables of the shared datapath, which has one memory and one ALU. The block sits between the instruction register's op/funct fields and the datapath control inputs inside `MIPS`.

## Interface
- `ILLEGAL_HALT`, default 1: 1 = an unknown opcode enters HALT; 0 = it is treated as a NOP and returns to FETCH.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `op`  in  6: IR[31:26], sampled in DECODE.
- `funct`  in  6: IR[5:0], used in RTYPEEX.
- `zero`  in  1: ALU zero flag.
- `pc_en`  out  1: PC load enable.
- `iord`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write`  out  1: data-memory write strobe.
- `ir_write`  out  1: IR load enable.
- `reg_dst`  out  1: destination register; 0 = rt, 1 = rd.
- `mem_to_reg`  out  1: write-back source; 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1: register-file write enable.
- `alu_src_a`  out  1: ALU A input; 0 = PC, 1 = register A.
- `alu_src_b`  out  2: ALU B input; 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_ctrl`  out  3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src`  out  2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4: current state, for debug and the testbench.
- `halted`  out  1: high while in HALT.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT (plus BNEEX under the macro).
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add, which precomputes the branch target.
  - lw or sw (100011, 101011) → MEMADR.
  - R-type (000000) → RTYPEEX.
  - beq (000100) → BEQEX.
  - addi (001000) → ADDIEX.
  - j (000010) → JEX.
  - Any other opcode → HALT if ILLEGAL_HALT, else FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=1, then FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives add). Next state is RTYPEWB.
- RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero. Next state is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JEX: pc_src=10, pc_en=1, then FETCH.
- HALT: all enables 0, halted=1. Only `rst` leaves HALT.
- Any output not listed for a state is 0.

## Timing
- Outputs are a pure function of `state`, except `pc_en` in BEQEX and BNEEX, which depends combinationally on `zero`.
- Instruction latency in cycles, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- `rst` high at an edge forces FETCH, including mid-instruction and from HALT.
- Reset values: state = FETCH, so the FETCH output set is active in the first cycle after reset, and halted = 0.
- No enable is ever asserted during a cycle in which `rst` is sampled high.

## Configuration
- `MIPS_MC_BNE_EN` defined: bne (000101) decodes to BNEEX, which matches BEQEX except pc_en = ~zero. Encoding 13.
- Macro absent: BNEEX does not exist, and opcode 000101 is illegal and follows the ILLEGAL_HALT rule.

## Structure
- Shared package `mips_pkg` holds:
  - state encodings: FETCH=0 … JEX=11, HALT=12, BNEEX=13;
  - opcode and funct localparams;
  - alu_ctrl, alu_src_b and pc_src codes.
- One sub-module, `mips_alu_dec`: combinational funct → alu_ctrl decode, used in RTYPEEX.

## Test plan
- Reset then lw (op 100011): states 0,1,2,3,4,0. ir_write is high only in cycle 0, and reg_write and mem_to_reg are high only in MEMWB.
- R-type sub (funct 100010): alu_ctrl = 110 in RTYPEEX, and reg_dst = 1 with reg_write = 1 in RTYPEWB. Total 4 cycles.
- beq with zero=1 gives pc_en=1 and pc_src=01 in BEQEX; with zero=0, pc_en=0. Both take 3 cycles.
- Opcode 111111 with ILLEGAL_HALT=1: state stays 12 and halted=1 for 20 cycles. A single-cycle `rst` pulse then returns the state to 0.
- Assert `rst` during MEMWR: mem_write=0 in the following cycle and state=FETCH.
- With `MIPS_MC_BNE_EN`: op 000101 and zero=0 give pc_en=1 in state 13. Without the macro, the same op halts.
